// File: rtl/bure_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bure_pkg
// Description : Shared types for the bure instruction-fetch stage: FSM state
//               encoding, the instruction-buffer entry layout and the
//               instruction size in bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package bure_pkg;

   localparam int INSTR_BYTES   = 4;
   // Widest address / instruction the buffer entry can carry; the fetch unit
   // narrows the stored fields back to its own ADDR_WIDTH / INSTR_WIDTH.
   localparam int ENTRY_ADDR_W  = 32;
   localparam int ENTRY_INSTR_W = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [ENTRY_INSTR_W-1:0] instr;
      logic [ENTRY_ADDR_W-1:0]  pc;
      logic                     misalign;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/bure_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bure_fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t between fetch and decode.
//               flush has priority over push and pop. Push and pop in the
//               same cycle are allowed, including when full.
// Ports       : clk, rst (async, active-high), push, pop, flush,
//               wdata (entry written on push), head (oldest entry),
//               count (number of valid entries)
// Revision    : 1.0 - initial release
// ============================================================================
module bure_fetch_fifo
   import bure_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  head,
   output logic [CW-1:0] count
);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop  = pop && (r_count != '0);
   assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= wdata;
            r_wr        <= ptr_inc(r_wr);
         end
         if (w_pop) r_rd <= ptr_inc(r_rd);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   assign head  = r_mem[r_rd];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bure_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : bure_fetch_unit
// Description : Instruction-fetch stage. Holds the PC, issues one outstanding
//               request at a time on a req/gnt/rvalid memory port and buffers
//               fetched words toward decode. prst redirects and flushes.
//               Optional macro BURE_FETCH_MISALIGN_EN: a misaligned redirect
//               target parks the unit in HALT and emits one marker entry.
// Ports       : clk, rst (async, active-high)
//               new_pc, prst                      - redirect
//               instr_valid/instr/instr_pc/
//               instr_misalign, instr_ready       - decode side
//               imem_req/imem_addr/imem_gnt/
//               imem_rvalid/imem_rdata            - instruction memory
// Revision    : 1.0 - initial release
// ============================================================================
module bure_fetch_unit
   import bure_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    FIFO_DEPTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  new_pc,
   input  logic                   prst,
   output logic                   instr_valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   output logic                   instr_misalign,
   input  logic                   instr_ready,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [INSTR_WIDTH-1:0] imem_rdata
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e          r_state;
   fetch_state_e          w_state_nxt;
   fetch_state_e          w_redir;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_req_pc;
   logic [ADDR_WIDTH-1:0] w_mark_pc;
   logic                  r_req;
   logic                  w_fire;
   logic                  w_bad;
   logic                  w_halt_pend;
   logic                  w_push_rsp;
   logic                  w_push_mark;
   logic                  w_pop;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_cnt_nxt;
   fetch_entry_t          w_wdata;
   fetch_entry_t          w_head;

   assign w_fire     = r_req & imem_gnt;
   assign w_pop      = instr_valid & instr_ready;
   assign w_push_rsp = (r_state == WAIT) & imem_rvalid & ~prst;
   // pc has already advanced past the outstanding request.
   assign w_req_pc   = r_pc - ADDR_WIDTH'(INSTR_BYTES);
   assign w_redir    = w_bad ? HALT : FETCH;

`ifdef BURE_FETCH_MISALIGN_EN
   logic       r_halt_pend;   // HALT follows once DRAIN completes
   logic       r_mark_done;   // marker already pushed for this HALT visit
   logic [1:0] r_halt_lo;     // low bits of the misaligned target

   assign w_bad = |new_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_halt_pend <= 1'b0;
         r_mark_done <= 1'b0;
         r_halt_lo   <= 2'b00;
      end else if (prst) begin
         r_halt_pend <= w_bad;
         r_mark_done <= 1'b0;
         r_halt_lo   <= new_pc[1:0];
      end else if (w_push_mark) begin
         r_mark_done <= 1'b1;
      end
   end

   assign w_halt_pend    = r_halt_pend;
   assign w_push_mark    = (r_state == HALT) & ~r_mark_done & ~prst;
   assign w_mark_pc      = {r_pc[ADDR_WIDTH-1:2], r_halt_lo};
   assign instr_misalign = w_head.misalign;
`else
   logic w_unused_ok;

   assign w_bad          = 1'b0;
   assign w_halt_pend    = 1'b0;
   assign w_push_mark    = 1'b0;
   assign w_mark_pc      = w_req_pc;
   assign instr_misalign = 1'b0;
   assign w_unused_ok    = ^{new_pc[1:0], w_head.misalign};
`endif

   always_comb begin
      w_wdata          = '0;
      w_wdata.instr    = w_push_mark ? '0 : ENTRY_INSTR_W'(imem_rdata);
      w_wdata.pc       = ENTRY_ADDR_W'(w_push_mark ? w_mark_pc : w_req_pc);
      w_wdata.misalign = w_push_mark;
   end

   // Occupancy after this edge; the registered request is derived from it so
   // a pop never frees a slot for a request in the same cycle.
   always_comb begin
      w_cnt_nxt = w_count;
      if (prst)                                            w_cnt_nxt = '0;
      else if ((w_push_rsp | w_push_mark) && !w_pop)       w_cnt_nxt = w_count + CW'(1);
      else if (!(w_push_rsp | w_push_mark) && w_pop)       w_cnt_nxt = w_count - CW'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      if (prst) begin
         case (r_state)
            FETCH:       w_state_nxt = w_fire ? DRAIN : w_redir;
            WAIT, DRAIN: w_state_nxt = imem_rvalid ? w_redir : DRAIN;
            default:     w_state_nxt = w_redir;
         endcase
      end else begin
         case (r_state)
            FETCH:   if (w_fire)      w_state_nxt = WAIT;
            WAIT:    if (imem_rvalid) w_state_nxt = FETCH;
            DRAIN:   if (imem_rvalid) w_state_nxt = w_halt_pend ? HALT : FETCH;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= (w_state_nxt == FETCH) && (w_cnt_nxt < CW'(FIFO_DEPTH));
         if (prst)        r_pc <= {new_pc[ADDR_WIDTH-1:2], 2'b00};
         else if (w_fire) r_pc <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
      end
   end

   bure_fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push_rsp | w_push_mark),
      .pop   (w_pop),
      .flush (prst),
      .wdata (w_wdata),
      .head  (w_head),
      .count (w_count)
   );

   assign instr_valid = (w_count != '0);
   assign instr       = w_head.instr[INSTR_WIDTH-1:0];
   assign instr_pc    = w_head.pc[ADDR_WIDTH-1:0];
   assign imem_req    = r_req;
   assign imem_addr   = r_req ? r_pc : '0;

endmodule
`default_nettype wire

// File: tb/tb_bure_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bure_fetch_unit
// Description : Self-checking bench for bure_fetch_unit. A transaction-level
//               model (expected buffered instructions, next fetch address,
//               outstanding request) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bure_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] new_pc = '0;
   logic        prst = 1'b0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_misalign;
   logic        instr_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;

   bure_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .new_pc         (new_pc),
      .prst           (prst),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_misalign (instr_misalign),
      .instr_ready    (instr_ready),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        mis;
   } ent_t;

   ent_t        q[$];
   logic [31:0] gaddr[$];
   logic [31:0] popped[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          p_gnt = 100, p_ready = 100, p_prst = 0, dly_max = 0;
   bit          force_prst = 0, prst_on_rv = 0;
   bit          outst = 0, stale = 0, halted = 0, mark_pend = 0;
   int          dly = 0;
   logic [31:0] exp_addr = '0, oaddr = '0, halt_pc = '0, force_pc = '0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] gat(input int i);
      return (i < gaddr.size()) ? gaddr[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pat(input int i);
      return (i < popped.size()) ? popped[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model to what
   // the coming rising edge must produce.
   task automatic step();
      bit          do_rv, do_gnt, do_prst, rdy, use_force;
      logic [31:0] npc;
      @(negedge clk);

      check_eq("valid", instr_valid, (q.size() != 0));
      if (q.size() != 0) begin
         check_eq("head_pc", instr_pc, q[0].pc);
         check_eq("head_instr", instr, q[0].ins);
         check_eq("head_mis", instr_misalign, q[0].mis);
      end
      check_eq("req", imem_req, (!outst && q.size() < DEPTH && !halted));
      if (imem_req) check_eq("addr", imem_addr, exp_addr);

      do_rv = 0;
      if (outst) begin
         if (dly == 0) do_rv = 1;
         else dly--;
      end
      do_gnt    = imem_req && !outst && ($urandom_range(0, 99) < p_gnt);
      rdy       = ($urandom_range(0, 99) < p_ready);
      use_force = force_prst || (prst_on_rv && do_rv);
      do_prst   = use_force || ($urandom_range(0, 99) < p_prst);
      npc       = $urandom();
      npc[1:0]  = ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b00;
      if (use_force) npc = force_pc;
      force_prst = 0;
      if (prst_on_rv && do_rv) prst_on_rv = 0;

      imem_gnt    = do_gnt;
      imem_rvalid = do_rv;
      imem_rdata  = do_rv ? memf(oaddr) : $urandom();
      instr_ready = rdy;
      prst        = do_prst;
      new_pc      = npc;

      if (instr_valid && rdy && q.size() != 0) begin
         popped.push_back(instr_pc);
         void'(q.pop_front());
      end
      if (halted && mark_pend && !outst && !do_prst) begin
         q.push_back('{pc: halt_pc, ins: 32'h0, mis: 1'b1});
         mark_pend = 0;
      end
      if (do_rv) begin
         if (!do_prst && !stale) q.push_back('{pc: oaddr, ins: memf(oaddr), mis: 1'b0});
         outst = 0;
      end
      if (do_gnt) begin
         gaddr.push_back(imem_addr);
         outst    = 1;
         stale    = 0;
         oaddr    = exp_addr;
         exp_addr = exp_addr + 32'd4;
         dly      = $urandom_range(0, dly_max);
      end
      if (do_prst) begin
         q.delete();
         gaddr.delete();
         popped.delete();
         stale    = outst;
         exp_addr = {npc[31:2], 2'b00};
`ifdef BURE_FETCH_MISALIGN_EN
         halted    = (npc[1:0] != 2'b00);
         mark_pend = halted;
         halt_pc   = npc;
`else
         halted    = 0;
`endif
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_valid", instr_valid, 0);
      check_eq("rst_instr", instr, 0);
      check_eq("rst_pc", instr_pc, 0);
      check_eq("rst_mis", instr_misalign, 0);
      check_eq("rst_req", imem_req, 0);
      check_eq("rst_addr", imem_addr, 0);
      rst = 1'b0;

      // 1: streaming from reset
      p_gnt = 100; p_ready = 100; dly_max = 0; p_prst = 0;
      repeat (8) step();
      check_eq("t1_g0", gat(0), 32'h0);
      check_eq("t1_g1", gat(1), 32'h4);
      check_eq("t1_g2", gat(2), 32'h8);
      check_eq("t1_p0", pat(0), 32'h0);
      check_eq("t1_p1", pat(1), 32'h4);
      check_eq("t1_p2", pat(2), 32'h8);

      // 2: decode stalled, buffer fills and fetch stops
      p_ready = 0;
      repeat (20) step();
      check_eq("t2_valid", instr_valid, 1);
      check_eq("t2_req", imem_req, 0);
      p_ready = 100;
      repeat (10) step();

      // 3: redirect while a request is outstanding without response
      dly_max = 3;
      for (int i = 0; i < 60; i++) begin
         if (outst && dly > 0) break;
         step();
      end
      check_eq("t3_wait_reached", (outst && dly > 0), 1);
      force_prst = 1; force_pc = 32'h100;
      step();
      dly_max = 0;
      repeat (12) step();
      check_eq("t3_g0", gat(0), 32'h100);
      check_eq("t3_p0", pat(0), 32'h100);

      // 4: redirect in the same cycle as the response
      dly_max = 1; prst_on_rv = 1; force_pc = 32'h300;
      for (int i = 0; i < 60; i++) begin
         if (!prst_on_rv) break;
         step();
      end
      check_eq("t4_fired", prst_on_rv, 0);
      step();
      check_eq("t4_req", imem_req, 1);
      check_eq("t4_addr", imem_addr, 32'h300);
      dly_max = 0;
      repeat (4) step();

      // 5: address wrap
      force_prst = 1; force_pc = 32'hFFFF_FFFC;
      step();
      repeat (10) step();
      check_eq("t5_g0", gat(0), 32'hFFFF_FFFC);
      check_eq("t5_g1", gat(1), 32'h0);
      check_eq("t5_p0", pat(0), 32'hFFFF_FFFC);
      check_eq("t5_p1", pat(1), 32'h0);

`ifdef BURE_FETCH_MISALIGN_EN
      // 6: misaligned redirect parks the unit with a marker
      p_ready = 0; force_prst = 1; force_pc = 32'h102;
      step();
      repeat (6) step();
      check_eq("t6_valid", instr_valid, 1);
      check_eq("t6_mis", instr_misalign, 1);
      check_eq("t6_pc", instr_pc, 32'h102);
      check_eq("t6_instr", instr, 32'h0);
      check_eq("t6_req", imem_req, 0);
      p_ready = 100; force_prst = 1; force_pc = 32'h200;
      step();
      repeat (8) step();
      check_eq("t6_g0", gat(0), 32'h200);
`endif

      // Random traffic
      p_gnt = 60; p_ready = 70; p_prst = 4; dly_max = 3;
      repeat (4000) step();
      p_prst = 0;
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
